score_link: RTL

Two-player score exchange framer between the local game logic and a byte-wide UART FIFO pair. Every PERIOD clocks it snapshots the local 24-bit BCD score and transmits a 6-byte checksummed frame through the UART TX FIFO. In parallel it parses the RX FIFO byte stream for frames from the opponent board and presents the opponent's ID and score to the character/overlay renderer. A timeout flags the link as stale.

---
 rtl/score_link.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/score_link.sv
// Score exchange framer: sends a checksummed 6-byte frame of the local BCD score every PERIOD,
// and parses the opponent's frames from the RX FIFO, flagging the link stale after TIMEOUT.
module score_link #(
  parameter logic [7:0] PLAYER_ID = 8'h01,
  parameter int         PERIOD    = 75000,
  parameter int         TIMEOUT   = 750000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [23:0] score_bcd,
  input  logic        tx_full,
  output logic        wr_uart,
  output logic [7:0]  w_data,
  input  logic        rx_empty,
  input  logic [7:0]  r_data,
  output logic        rd_uart,
  output logic [23:0] opp_score,
  output logic [7:0]  opp_id,
  output logic        opp_valid,
  output logic        frame_err
);
  localparam logic [7:0]    SYNC     = 8'hA5;
  localparam int            PW       = $clog2(PERIOD);
  localparam int            TW       = $clog2(TIMEOUT);
  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SEND} tx_st_e;
  typedef enum logic [2:0] {RX_HUNT, RX_ID, RX_S2, RX_S1, RX_S0, RX_CK} rx_st_e;

  tx_st_e        tx_st_q, tx_st_d;
  logic [PW-1:0] per_q, per_d;
  logic [23:0]   snap_q, snap_d;
  logic [2:0]    idx_q, idx_d;
  logic          wr_prev_q, push;
  logic [7:0]    tx_byte;

  always_comb begin
    tx_st_d = tx_st_q;
    per_d   = per_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    push    = (tx_st_q == TX_SEND) && !tx_full && !wr_prev_q;
    case (idx_q)
      3'd0:    tx_byte = SYNC;
      3'd1:    tx_byte = PLAYER_ID;
      3'd2:    tx_byte = snap_q[23:16];
      3'd3:    tx_byte = snap_q[15:8];
      3'd4:    tx_byte = snap_q[7:0];
      default: tx_byte = PLAYER_ID ^ snap_q[23:16] ^ snap_q[15:8] ^ snap_q[7:0];
    endcase
    case (tx_st_q)
      TX_IDLE: begin
        if (per_q == PER_LAST) begin
          tx_st_d = TX_LOAD;
          per_d   = '0;
        end else begin
          per_d = per_q + PW'(1);
        end
      end
      TX_LOAD: begin
        snap_d  = score_bcd;
        idx_d   = '0;
        tx_st_d = TX_SEND;
      end
      TX_SEND: begin
        if (push) begin
          if (idx_q == 3'd5) tx_st_d = TX_IDLE;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

  assign wr_uart = push;
  assign w_data  = (tx_st_q == TX_SEND) ? tx_byte : 8'h00;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      tx_st_q   <= TX_IDLE;
      per_q     <= '0;
      snap_q    <= '0;
      idx_q     <= '0;
      wr_prev_q <= 1'b0;
    end else begin
      tx_st_q   <= tx_st_d;
      per_q     <= per_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      wr_prev_q <= push;
    end
  end

  rx_st_e        rx_st_q, rx_st_d;
  logic          rd_prev_q, pop, accept, ck_ok;
  logic [7:0]    bid_q, bid_d;
  logic [23:0]   bsc_q, bsc_d;
  logic [23:0]   opp_score_q, opp_score_d;
  logic [7:0]    opp_id_q, opp_id_d;
  logic          opp_valid_q, opp_valid_d, err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;

  function automatic logic bcd_ok(input logic [23:0] v);
    bcd_ok = 1'b1;
    for (int i = 0; i < 6; i++)
      if (v[4*i +: 4] > 4'd9) bcd_ok = 1'b0;
  endfunction

  assign pop   = !rx_empty && !rd_prev_q;
  assign ck_ok = (r_data == (bid_q ^ bsc_q[23:16] ^ bsc_q[15:8] ^ bsc_q[7:0])) && bcd_ok(bsc_q);

  always_comb begin
    rx_st_d     = rx_st_q;
    bid_d       = bid_q;
    bsc_d       = bsc_q;
    opp_score_d = opp_score_q;
    opp_id_d    = opp_id_q;
    opp_valid_d = opp_valid_q;
    tmo_d       = tmo_q;
    err_d       = 1'b0;
    accept      = 1'b0;
    if (pop) begin
      case (rx_st_q)
        RX_HUNT: if (r_data == SYNC) rx_st_d = RX_ID;
        RX_CK: begin
          rx_st_d = RX_HUNT;
          if (ck_ok) accept = 1'b1;
          else       err_d  = 1'b1;
        end
        default: begin
          // A sync byte inside the payload means we lost alignment: restart on it.
          if (r_data == SYNC) begin
            err_d   = 1'b1;
            rx_st_d = RX_ID;
          end else begin
            case (rx_st_q)
              RX_ID:   begin bid_d         = r_data; rx_st_d = RX_S2; end
              RX_S2:   begin bsc_d[23:16]  = r_data; rx_st_d = RX_S1; end
              RX_S1:   begin bsc_d[15:8]   = r_data; rx_st_d = RX_S0; end
              RX_S0:   begin bsc_d[7:0]    = r_data; rx_st_d = RX_CK; end
              default: rx_st_d = RX_HUNT;
            endcase
          end
        end
      endcase
    end
    if (accept) begin
      opp_score_d = bsc_q;
      opp_id_d    = bid_q;
      opp_valid_d = 1'b1;
      tmo_d       = '0;
    end else if (opp_valid_q) begin
      if (tmo_q == TMO_LAST) begin
        opp_valid_d = 1'b0;
        tmo_d       = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  assign rd_uart   = pop;
  assign opp_score = opp_score_q;
  assign opp_id    = opp_id_q;
  assign opp_valid = opp_valid_q;
  assign frame_err = err_q;

  // rd_prev_q resets high so rd_uart stays low while reset is held.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      rx_st_q     <= RX_HUNT;
      rd_prev_q   <= 1'b1;
      bid_q       <= '0;
      bsc_q       <= '0;
      opp_score_q <= '0;
      opp_id_q    <= '0;
      opp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
    end else begin
      rx_st_q     <= rx_st_d;
      rd_prev_q   <= pop;
      bid_q       <= bid_d;
      bsc_q       <= bsc_d;
      opp_score_q <= opp_score_d;
      opp_id_q    <= opp_id_d;
      opp_valid_q <= opp_valid_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end
endmodule
